arbiter_rr_hold: RTL and testbench
==================================

// Module: arbiter_rr_hold
// PURPOSE
//  Registered round-robin arbiter with grant hold; the sequential companion to the
//  daisy-chain ArbiterN. Shares one resource among n requesters: grants one at a time,
//  holds the grant while the owner keeps requesting, then rotates priority.
//  Optional hold timeout revokes a grant from a stuck owner.
// PARAMETERS
//  n         8   number of requesters; index 0 = slot 0 of rotation; n >= 1
//  HOLD_MAX  16  max cycles a grant is held; 0 = no timeout
//  IW        derived: max(1,$clog2(n)), width of gid/ptr
//  CW        derived: max(1,$clog2(HOLD_MAX+1)), width of hold counter
// PORTS
//  clk      in   1      clock; all state changes on rising edge
//  reset    in   1      synchronous, active-high reset
//  r        in   [0:n-1] request vector, level; r[i]=1 requester i wants resource
//  g        out  [0:n-1] grant vector, registered, one-hot or zero
//  busy     out  1      1 while any g bit set
//  gid      out  IW     index of current/last granted requester
//  timeout  out  1      one-cycle pulse: grant revoked by HOLD_MAX expiry
// BEHAVIOUR
//  Reset (reset=1 at edge): g=0, busy=0, gid=0, timeout=0, ptr=0, cnt=0, state=IDLE.
//   Reset wins over every other event, including mid-grant; g drops next cycle.
//  States: IDLE, GRANT.
//  IDLE: if r==0, stay; outputs unchanged except timeout=0.
//   If r!=0: winner = first i with r[i]=1 scanning ptr, ptr+1, ..., n-1, 0, ..., ptr-1.
//   Next edge: g=onehot(winner), gid=winner, busy=1, cnt=1, state=GRANT.
//   Latency: request present at edge k -> g visible after edge k (1 cycle).
//  GRANT (owner = gid):
//   r[gid]=0 -> release: g=0, busy=0, ptr=(gid==n-1)?0:gid+1, state=IDLE.
//   else HOLD_MAX!=0 and cnt==HOLD_MAX -> revoke: same as release, plus timeout=1
//    for exactly that one cycle.
//   else hold: g unchanged, cnt=cnt+1 (saturates, never wraps).
//   Requests from non-owners are ignored in GRANT; they stay pending.
//  Turnaround: after every release/revoke, g=0 for at least one cycle before the next
//   grant; no back-to-back grants, even to a different requester.
//  Fairness: the owner just released has lowest priority at the next arbitration.
//   With all r=1 and no releases, grants rotate 0,1,...,n-1,0 with wrap at n-1.
//  A revoked owner that keeps r=1 re-arbitrates normally and gets its next turn.
//  Invariants: g has at most one bit set; busy == |g; g[gid]==busy.
//  n=1: ptr stays 0; requester 0 regranted after each turnaround cycle.
//  gid keeps its value in IDLE; it is meaningful only while busy=1.
// TESTING
//  1 reset=1 for 2 cycles, r=8'hFF -> g=0, busy=0, gid=0, timeout=0 on every cycle.
//  2 n=8, r[3]=1 only, held 5 cycles then dropped -> g[3]=1 one cycle after r[3]
//    rises, for 5 cycles; g=0 one cycle after r[3] falls; ptr=4.
//  3 all r=1, each owner drops r for one cycle after 2 granted cycles -> gid sequence
//    0,1,2,...,7,0 with a g=0 cycle between grants.
//  4 HOLD_MAX=4, r[5] held for 20 cycles -> g[5]=1 for 4 cycles, then g=0 and
//    timeout=1 for one cycle, then g[5]=1 again (sole requester).
//  5 ptr=7 (after owner 6 releases), r[2]=r[7]=1 -> 7 granted; after 7 releases,
//    ptr wraps to 0 and 2 is granted next.
//  6 r[1] owner mid-grant, reset=1 for one cycle -> g=0, ptr=0 next cycle; with
//    r[1]=r[0]=1 after reset, requester 0 is granted first.

Source files
------------

// File: rtl/arbiter_rr_hold.sv
// Registered round-robin arbiter with grant hold and an optional hold timeout.
// One requester owns the resource at a time. Ownership is held while the owner
// keeps requesting. Priority then rotates past the released owner.
module arbiter_rr_hold #(
    parameter int n        = 8,
    parameter int HOLD_MAX = 16,
    parameter int IW       = (n > 1) ? $clog2(n) : 1,
    parameter int CW       = ($clog2(HOLD_MAX + 1) > 1) ? $clog2(HOLD_MAX + 1) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [0:n-1]  r,
    output logic [0:n-1]  g,
    output logic          busy,
    output logic [IW-1:0] gid,
    output logic          timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [0:n-1]  g_n;
    logic          busy_n;
    logic [IW-1:0] gid_n;
    logic          timeout_n;

    logic          found;
    logic [IW-1:0] win;
    int unsigned   idx;

    // Rotating priority scan: first requester at or after ptr, wrapping at n-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < n; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if (!found && r[IW'(idx)]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    // Next-state and next-output logic; timeout is a single-cycle pulse.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cnt_n     = cnt;
        g_n       = g;
        busy_n    = busy;
        gid_n     = gid;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    g_n      = '0;
                    g_n[win] = 1'b1;
                    gid_n    = win;
                    busy_n   = 1'b1;
                    cnt_n    = CW'(1);
                    state_n  = GRANT;
                end
            end
            GRANT: begin
                if (!r[gid] || (HOLD_MAX != 0 && cnt == CW'(HOLD_MAX))) begin
                    // Release and revoke share the same path; only the pulse differs.
                    g_n       = '0;
                    busy_n    = 1'b0;
                    ptr_n     = (gid == IW'(n - 1)) ? '0 : gid + IW'(1);
                    state_n   = IDLE;
                    timeout_n = r[gid];
                end else if (cnt != '1) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            g       <= '0;
            busy    <= 1'b0;
            gid     <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            g       <= g_n;
            busy    <= busy_n;
            gid     <= gid_n;
            timeout <= timeout_n;
        end
    end

endmodule

// File: tb/tb_arbiter_rr_hold.sv
// Directed bench for arbiter_rr_hold: default config, short-timeout config, n=1.
module tb_arbiter_rr_hold;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT a: n=8, HOLD_MAX=16
    logic       rsta;
    logic [0:7] ra, ga;
    logic       busya, toa;
    logic [2:0] gida;
    // DUT b: n=8, HOLD_MAX=4
    logic       rstb;
    logic [0:7] rb, gb;
    logic       busyb, tob;
    logic [2:0] gidb;
    // DUT c: n=1, no timeout
    logic       rstc;
    logic [0:0] rc, gc;
    logic       busyc, toc;
    logic [0:0] gidc;

    arbiter_rr_hold #(.n(8), .HOLD_MAX(16)) dut_a (
        .clk(clk), .reset(rsta), .r(ra), .g(ga), .busy(busya), .gid(gida), .timeout(toa));
    arbiter_rr_hold #(.n(8), .HOLD_MAX(4)) dut_b (
        .clk(clk), .reset(rstb), .r(rb), .g(gb), .busy(busyb), .gid(gidb), .timeout(tob));
    arbiter_rr_hold #(.n(1), .HOLD_MAX(0)) dut_c (
        .clk(clk), .reset(rstc), .r(rc), .g(gc), .busy(busyc), .gid(gidc), .timeout(toc));

    function automatic logic [0:7] oh(input int i);
        logic [0:7] v;
        v = '0;
        v[3'(i)] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [0:7] eg, input int egid, input logic eto);
        chk({tag, ".g"}, 32'(ga), 32'(eg));
        chk({tag, ".busy"}, 32'(busya), 32'(|eg));
        chk({tag, ".gid"}, 32'(gida), 32'(egid));
        chk({tag, ".timeout"}, 32'(toa), 32'(eto));
    endtask

    task automatic chk_b(input string tag, input logic [0:7] eg, input int egid, input logic eto);
        chk({tag, ".g"}, 32'(gb), 32'(eg));
        chk({tag, ".busy"}, 32'(busyb), 32'(|eg));
        chk({tag, ".gid"}, 32'(gidb), 32'(egid));
        chk({tag, ".timeout"}, 32'(tob), 32'(eto));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        // 1: reset held 2 cycles with all requests high
        rsta = 1'b1; rstb = 1'b1; rstc = 1'b1;
        ra = 8'hFF; rb = 8'hFF; rc = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_a("rst_a", 8'h00, 0, 1'b0);
            chk_b("rst_b", 8'h00, 0, 1'b0);
        end

        // 2: single requester 3 held 5 cycles, then ptr=4 picks 5 over 1
        rsta = 1'b0; ra = 8'h00;
        tick();
        chk_a("idle", 8'h00, 0, 1'b0);
        ra[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_a("hold3", oh(3), 3, 1'b0);
        end
        ra = 8'h00;
        tick();
        chk_a("rel3", 8'h00, 3, 1'b0);
        ra[1] = 1'b1; ra[5] = 1'b1;
        tick();
        chk_a("ptr4", oh(5), 5, 1'b0);
        ra = 8'h00;
        tick();
        chk_a("rel5", 8'h00, 5, 1'b0);

        // 3: all request, owner drops for one cycle after 2 granted cycles
        rsta = 1'b1;
        tick();
        rsta = 1'b0; ra = 8'hFF;
        for (int j = 0; j < 9; j++) begin
            tick();
            chk_a("rot_g1", oh(j % 8), j % 8, 1'b0);
            tick();
            chk_a("rot_g2", oh(j % 8), j % 8, 1'b0);
            ra[3'(j % 8)] = 1'b0;
            tick();
            chk_a("rot_gap", 8'h00, j % 8, 1'b0);
            ra[3'(j % 8)] = 1'b1;
        end

        // 5: ptr=7 after owner 6, then wrap to 0 so 2 follows 7
        rsta = 1'b1;
        tick();
        rsta = 1'b0; ra = 8'h00; ra[6] = 1'b1;
        tick();
        chk_a("own6", oh(6), 6, 1'b0);
        ra = 8'h00;
        tick();
        chk_a("rel6", 8'h00, 6, 1'b0);
        ra[2] = 1'b1; ra[7] = 1'b1;
        tick();
        chk_a("win7", oh(7), 7, 1'b0);
        ra[7] = 1'b0;
        tick();
        chk_a("rel7", 8'h00, 7, 1'b0);
        tick();
        chk_a("wrap2", oh(2), 2, 1'b0);
        ra = 8'h00;
        tick();
        chk_a("rel2", 8'h00, 2, 1'b0);

        // 6: reset mid-grant of owner 1; afterwards 0 beats 1 (ptr=0)
        ra[1] = 1'b1;
        tick();
        chk_a("own1", oh(1), 1, 1'b0);
        tick();
        chk_a("hold1", oh(1), 1, 1'b0);
        rsta = 1'b1; ra[0] = 1'b1;
        tick();
        chk_a("midrst", 8'h00, 0, 1'b0);
        rsta = 1'b0;
        tick();
        chk_a("after_rst", oh(0), 0, 1'b0);

        // 4: HOLD_MAX=4, sole requester 5 held 20 cycles -> 4 granted, 1 revoked
        rstb = 1'b0; rb = 8'h00; rb[5] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c % 5 == 0) chk_b("revoke5", 8'h00, 5, 1'b1);
            else            chk_b("tgrant5", oh(5), 5, 1'b0);
        end
        rb = 8'h00;
        tick();
        chk_b("tidle", 8'h00, 5, 1'b0);

        // n=1 with no timeout: long hold, turnaround, regrant
        rstc = 1'b0; rc = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("n1.g", 32'(gc), 32'(1));
            chk("n1.to", 32'(toc), 32'(0));
        end
        rc = 1'b0;
        tick();
        chk("n1.rel", 32'(gc), 32'(0));
        chk("n1.busy", 32'(busyc), 32'(0));
        rc = 1'b1;
        tick();
        chk("n1.regrant", 32'(gc), 32'(1));
        chk("n1.gid", 32'(gidc), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
